// File: rtl/rk_crtc.sv
// rk_crtc: 8275-style character-row controller. Rows are DMA-filled into a double-buffered store for rk_video.
// Optional blink support is enabled by defining RK_CRTC_BLINK_EN.
module rk_crtc #(
    parameter int CHARS_PER_ROW = 78,
    parameter int ROWS          = 30,
    parameter int LINES_PER_ROW = 10,
    parameter int TOP_BLANK     = 40,
    parameter int UL_LINE       = 9
) (
    input  logic       clk50mhz,
    input  logic       reset,
    input  logic       hr,
    input  logic       vr,
    input  logic       cce,
    input  logic [6:0] cur_x,
    input  logic [5:0] cur_y,
    output logic       drq,
    input  logic       dack,
    input  logic       dma_wr,
    input  logic [7:0] din,
    output logic [6:0] ichar,
    output logic [3:0] line,
    output logic       vsp,
    output logic       lten,
    output logic       rvv,
    output logic       underrun
);
    typedef enum logic {IDLE, REQ} dma_t;
    dma_t st, st_n;
    logic hr_q, vr_q, active, top, disp, filled, row_bad, rev, blink, ul, eor;
    logic [5:0] scan, row, new_row;
    logic [3:0] ln;
    logic [6:0] col, ptr;
    logic [7:0] mem [2][CHARS_PER_ROW];
    logic [7:0] b;
    logic hr_rise, vr_rise, line_step, top_end, row_end, swap, fill_req;
    logic wr, last, full, vis, cell_on, here, cur_phase, blink_off;

    assign hr_rise   = hr & ~hr_q;
    assign vr_rise   = vr & ~vr_q;
    assign line_step = hr_rise && !vr_rise && active;
    assign top_end   = top && scan == 6'(TOP_BLANK - 1);
    assign row_end   = !top && ln == 4'(LINES_PER_ROW - 1) && row + 6'd1 < 6'(ROWS);
    assign swap      = line_step && (top_end || row_end);
    assign new_row   = top ? 6'd0 : row + 6'd1;
    assign fill_req  = vr_rise || (swap && new_row + 6'd1 < 6'(ROWS));
    assign wr        = st == REQ && dack && dma_wr;
    assign last      = wr && ptr == 7'(CHARS_PER_ROW - 1);
    // A final byte landing on the swap clock still completes the outgoing fill
    assign full      = filled || last;
    assign drq       = st == REQ;
    assign b         = mem[disp][col];
    assign vis       = active && !top && row < 6'(ROWS) && col < 7'(CHARS_PER_ROW) && !row_bad;
    assign cell_on   = vis && !b[7] && !eor;
    assign here      = col == cur_x && row == cur_y;

`ifdef RK_CRTC_BLINK_EN
    logic [4:0] frame;
    always_ff @(posedge clk50mhz or posedge reset)
        if (reset) frame <= '0;
        else if (vr_rise) frame <= frame + 5'd1;
    assign cur_phase = frame[3];
    assign blink_off = ~frame[4];
`else
    assign cur_phase = 1'b1;
    assign blink_off = 1'b0;
`endif

    always_ff @(posedge clk50mhz or posedge reset)
        if (reset) st <= IDLE;
        else st <= st_n;

    // A swap abandons any outstanding fill; a new request always restarts it
    always_comb st_n = fill_req ? REQ : (swap || last) ? IDLE : st;

    always_ff @(posedge clk50mhz)
        if (wr) mem[~disp][ptr] <= din;

    always_ff @(posedge clk50mhz or posedge reset) begin
        if (reset) begin
            hr_q     <= 1'b1;
            vr_q     <= 1'b1;
            active   <= 1'b0;
            top      <= 1'b0;
            disp     <= 1'b0;
            filled   <= 1'b0;
            row_bad  <= 1'b0;
            scan     <= '0;
            row      <= '0;
            ln       <= '0;
            col      <= '0;
            ptr      <= '0;
            rev      <= 1'b0;
            blink    <= 1'b0;
            ul       <= 1'b0;
            eor      <= 1'b0;
            ichar    <= '0;
            line     <= '0;
            vsp      <= 1'b1;
            lten     <= 1'b0;
            rvv      <= 1'b0;
            underrun <= 1'b0;
        end else begin
            hr_q     <= hr;
            vr_q     <= vr;
            underrun <= swap && !full;
            ptr      <= (fill_req || swap) ? 7'd0 : wr ? ptr + 7'd1 : ptr;
            filled   <= (fill_req || swap) ? 1'b0 : last ? 1'b1 : filled;
            if (vr_rise) begin
                active  <= 1'b1;
                top     <= 1'b1;
                scan    <= '0;
                row     <= '0;
                ln      <= '0;
                row_bad <= 1'b0;
            end else if (line_step) begin
                if (top) begin
                    scan <= scan + 6'd1;
                    top  <= !top_end;
                end else begin
                    ln <= ln == 4'(LINES_PER_ROW - 1) ? 4'd0 : ln + 4'd1;
                    if (ln == 4'(LINES_PER_ROW - 1) && row != 6'(ROWS)) row <= row + 6'd1;
                end
                if (swap) begin
                    disp    <= ~disp;
                    row_bad <= !full;
                end
            end
            col <= hr_rise ? 7'd0 : (cce && !(&col)) ? col + 7'd1 : col;
            if (hr_rise) begin
                rev   <= 1'b0;
                blink <= 1'b0;
                ul    <= 1'b0;
                eor   <= 1'b0;
            end else if (cce && vis && !eor) begin
                if (b[7:6] == 2'b10) {rev, blink, ul} <= {b[4], b[1], b[0]};
                if (b == 8'hF1) eor <= 1'b1;
            end
            if (cce) begin
                ichar <= cell_on ? b[6:0] : 7'd0;
                line  <= ln;
                rvv   <= cell_on && rev;
                lten  <= cell_on && ln == 4'(UL_LINE) && (ul || (here && cur_phase));
                vsp   <= !cell_on || (blink && blink_off);
            end
        end
    end
endmodule

// File: tb/tb_rk_crtc.sv
// tb_rk_crtc: directed frame-level bench for rk_crtc using reduced geometry.
module tb_rk_crtc;
    localparam int CPR = 8, NR = 6, LPR = 4, TB = 3, UL = 3;

    logic       clk50mhz = 1'b0, reset = 1'b1, hr = 1'b1, vr = 1'b1, cce = 1'b0;
    logic [6:0] cur_x = 7'd5;
    logic [5:0] cur_y = 6'd2;
    logic       dack = 1'b0, dma_wr = 1'b0;
    logic [7:0] din = 8'h00;
    logic       drq, vsp, lten, rvv, underrun;
    logic [6:0] ichar;
    logic [3:0] line;

    int  checks = 0, errors = 0, ur_cnt = 0, ur_exp = 0, drq_rises = 0;
    int  hrc = 0, frame_no = 0, skip_row = -1, bad_row = -1;
    bit  active = 1'b0, pend = 1'b0;
    logic drq_d = 1'b0;
    logic [7:0] rd [NR][CPR];

    rk_crtc #(.CHARS_PER_ROW(CPR), .ROWS(NR), .LINES_PER_ROW(LPR), .TOP_BLANK(TB), .UL_LINE(UL)) dut (
        .clk50mhz(clk50mhz), .reset(reset), .hr(hr), .vr(vr), .cce(cce),
        .cur_x(cur_x), .cur_y(cur_y), .drq(drq), .dack(dack), .dma_wr(dma_wr), .din(din),
        .ichar(ichar), .line(line), .vsp(vsp), .lten(lten), .rvv(rvv), .underrun(underrun)
    );

    always #5 clk50mhz = ~clk50mhz;

    always @(negedge clk50mhz) begin
        if (underrun === 1'b1) ur_cnt++;
        if (drq === 1'b1 && drq_d !== 1'b1) drq_rises++;
        drq_d = drq;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk50mhz);
        #1;
    endtask

    task automatic serve(input int r);
        chk("drq_req", 32'(drq), 1);
        for (int k = 0; k < CPR; k++) begin
            dack = 1'b1; dma_wr = 1'b1; din = rd[r][k];
            tick();
        end
        dack = 1'b0; dma_wr = 1'b0;
        chk("drq_done", 32'(drq), 0);
    endtask

    task automatic do_line(input bit v, input int ncols);
        int d, row, ln, req;
        logic [7:0] bb;
        bit rv, bl, u, eo, on, cp, bo, el, er, ev;
        logic [6:0] ei;
        chk("drq_line", 32'(drq), 32'(pend));
        hr = 1'b0;
        if (v) vr = 1'b0;
        if (!pend) begin dack = 1'b1; dma_wr = 1'b1; din = 8'h00; end
        tick(); tick();
        dack = 1'b0; dma_wr = 1'b0; hr = 1'b1; vr = 1'b1;
        if (v) begin hrc = 0; frame_no++; bad_row = -1; active = 1'b1; end
        else hrc++;
        d   = hrc - TB;
        row = (active && d >= 0) ? d / LPR : NR;
        ln  = (active && d >= 0) ? d % LPR : 0;
        req = -1;
        if (v) req = 0;
        else if (active && d >= 0 && ln == 0 && row < NR) begin
            if (row == skip_row) begin bad_row = row; ur_exp++; pend = 1'b0; end
            if (row + 1 < NR) req = row + 1;
        end
        tick(); tick();
        if (req >= 0) begin
            if (req == skip_row) pend = 1'b1;
            else serve(req);
        end
`ifdef RK_CRTC_BLINK_EN
        cp = frame_no[3]; bo = !frame_no[4];
`else
        cp = 1'b1; bo = 1'b0;
`endif
        rv = 0; bl = 0; u = 0; eo = 0;
        for (int c = 0; c < ncols; c++) begin
            cce = 1'b1;
            tick();
            bb = (row < NR && c < CPR) ? rd[row][c] : 8'hFF;
            on = row < NR && row != bad_row && c < CPR && !eo && !bb[7];
            ei = on ? bb[6:0] : 7'd0;
            er = on && rv;
            el = on && ln == UL && (u || (c == int'(cur_x) && row == int'(cur_y) && cp));
            ev = !on || (bl && bo);
            if (row < NR && row != bad_row && c < CPR && !eo) begin
                if (bb[7:6] == 2'b10) begin rv = bb[4]; bl = bb[1]; u = bb[0]; end
                if (bb == 8'hF1) eo = 1'b1;
            end
            chk($sformatf("cell f%0d r%0d l%0d c%0d", frame_no, row, ln, c),
                32'({ichar, vsp, lten, rvv, line}), 32'({ei, ev, el, er, 4'(ln)}));
        end
        cce = 1'b0;
    endtask

    task automatic do_frame();
        do_line(1'b1, CPR + 2);
        for (int i = 0; i < TB + NR * LPR; i++) do_line(1'b0, CPR + 2);
        chk("underrun_count", 32'(ur_cnt), 32'(ur_exp));
    endtask

    initial begin
        for (int r = 0; r < NR; r++)
            for (int c = 0; c < CPR; c++) rd[r][c] = 8'h41;
        rd[1] = '{8'h41, 8'h90, 8'h42, 8'hF1, 8'h43, 8'h44, 8'h44, 8'h44};
        rd[2] = '{8'h50, 8'h51, 8'h52, 8'h53, 8'h54, 8'h55, 8'h56, 8'h57};
        rd[3] = '{8'h41, 8'h81, 8'h42, 8'hC5, 8'h83, 8'h43, 8'h80, 8'h7F};
        rd[4] = '{8'h82, 8'h44, 8'h45, 8'hF1, 8'h90, 8'h46, 8'h47, 8'h48};
        rd[5] = '{8'h00, 8'h12, 8'h34, 8'hB0, 8'h56, 8'h7F, 8'hE0, 8'h02};

        tick(); tick();
        chk("rst_drq", 32'(drq), 0);
        chk("rst_outs", 32'({ichar, line, vsp, lten, rvv, underrun}), 32'({7'd0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0}));
        reset = 1'b0;
        tick();
        do_line(1'b0, CPR + 2);

        do_frame();
        chk("bursts_frame1", 32'(drq_rises), NR);
        for (int f = 2; f <= 9; f++) do_frame();

        skip_row = 3;
        do_frame();
        skip_row = -1;

        do_line(1'b1, CPR + 2);
        for (int i = 0; i < TB + LPR - 2; i++) do_line(1'b0, CPR + 2);
        do_line(1'b0, CPR - 2);
        chk("pre_rst_vsp", 32'(vsp), 0);
        hr = 1'b0;
        tick(); tick();
        hr = 1'b1;
        tick(); tick();
        chk("burst_started", 32'(drq), 1);
        for (int k = 0; k < 3; k++) begin
            dack = 1'b1; dma_wr = 1'b1; din = 8'h55;
            tick();
        end
        reset = 1'b1;
        #1;
        chk("rst_async_drq", 32'(drq), 0);
        chk("rst_async_vsp", 32'(vsp), 1);
        dack = 1'b0; dma_wr = 1'b0;
        tick();
        reset = 1'b0;
        active = 1'b0; pend = 1'b0; frame_no = 0; hrc = 0; bad_row = -1;
        do_line(1'b0, CPR + 2);
        do_line(1'b0, CPR + 2);
        do_frame();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
